// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment display blocks.
// Active-low segment patterns, seg[6:0] = {g,f,e,d,c,b,a}; a 0 bit lights a segment.
// Pure constants, no logic.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern decoder.
// Latency: purely combinational.
// Backpressure: none.
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Map each nibble value to its glyph ('b' and 'd' in lower case).
  always_comb begin
    seg_n = SEG_OFF;
    unique case (hex)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode hex display driver, one digit lit per scan slot.
// Latency: an/seg registered, 1 cycle behind the digit index / frame state.
// Backpressure: none; display is sampled once per frame and otherwise ignored.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int SCAN_HZ       = 1000,
  parameter int DIGITS        = 8,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   display,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_start
);

  // DIV must be at least 2 so the prescaler has a non-zero width.
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] frame_q, frame_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                frame_start_q, frame_start_d;

  logic                tick;
  logic                last_digit;
  logic [3:0]          cur_nib;
  logic [6:0]          cur_glyph;
  logic [DIGITS-1:0]   blank_mask;
  logic                lead_zero;
  logic                cur_blank;

  // Prescaler, digit index and once-per-frame capture of the display value.
  always_comb begin
    tick          = (presc_q == PW'(DIV - 1));
    last_digit    = (idx_q == IW'(DIGITS - 1));
    presc_d       = tick ? '0 : presc_q + 1'b1;
    idx_d         = idx_q;
    frame_d       = frame_q;
    frame_start_d = 1'b0;
    if (tick) begin
      idx_d = last_digit ? '0 : idx_q + 1'b1;
      if (last_digit) begin
        frame_d       = display;
        frame_start_d = 1'b1;
      end
    end
  end

  // Leading-zero blank mask: digit i is blank when it and every digit above it are zero.
  // Digit 0 is never blanked so a zero value still shows a single '0'.
  always_comb begin
    lead_zero  = 1'b1;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (frame_q[4*i +: 4] != 4'h0) lead_zero = 1'b0;
      blank_mask[i] = (BLANK_LEADING != 0) && (i != 0) && lead_zero;
    end
  end

  // Select the nibble and blank flag of the digit currently being scanned.
  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = frame_q[4*i +: 4];
        cur_blank = blank_mask[i];
      end
    end
  end

  hex_to_seg7 u_dec (
    .hex   (cur_nib),
    .seg_n (cur_glyph)
  );

  // Next anode/segment drive; a blank digit turns everything off.
  always_comb begin
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = cur_glyph;
    if (cur_blank) begin
      an_d  = '1;
      seg_d = SEG_OFF;
    end
  end

  // State and output registers; reset restarts the scan at digit 0 with frame 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=4, 8 digits.
// Two instances share stimulus: one blanks leading zeros, one shows all digits.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] display;
  logic [7:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;
  logic        fs, fs_nb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.CLK_HZ(8), .SCAN_HZ(2), .DIGITS(8), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .display(display), .an(an), .seg(seg), .frame_start(fs)
  );

  seg7_scan_driver #(.CLK_HZ(8), .SCAN_HZ(2), .DIGITS(8), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst(rst), .display(display), .an(an_nb), .seg(seg_nb), .frame_start(fs_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at the sample where frame_start is high; checks the following 32 cycles.
  // ea/es hold expected an/seg per digit (digit 0 in the low bits).
  task automatic show_frame(input string tag, input logic [63:0] ea, input logic [55:0] es,
                            input int chg_at, input logic [31:0] chg_val, input bit chk_nb);
    int fs_cnt = 0;
    int ff_cnt = 0;
    logic [7:0] walk;
    for (int k = 0; k < 32; k++) begin
      if (k == chg_at) display = chg_val;
      step();
      chk($sformatf("%s_an_d%0d", tag, k / 4), an, ea[8*(k/4) +: 8]);
      chk($sformatf("%s_seg_d%0d", tag, k / 4), seg, es[7*(k/4) +: 7]);
      if (fs) fs_cnt++;
      if (chk_nb) begin
        walk = 8'h01 << (k / 4);
        walk = ~walk;
        chk($sformatf("%s_nb_an_d%0d", tag, k / 4), an_nb, walk);
        chk($sformatf("%s_nb_seg_d%0d", tag, k / 4), seg_nb, 7'h40);
        if (an_nb == 8'hFF) ff_cnt++;
      end
    end
    chk({tag, "_fs_count"}, fs_cnt, 1);
    chk({tag, "_fs_last"}, fs, 1'b1);
    if (chk_nb) chk({tag, "_nb_never_ff"}, ff_cnt, 0);
  endtask

  localparam logic [63:0] WALK  = 64'h7FBF_DFEF_F7FB_FDFE;
  localparam logic [63:0] ONLY0 = 64'hFFFF_FFFF_FFFF_FFFE;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fs_early;
    rst     = 1'b1;
    display = 32'h1234_5678;

    // 1. Reset state, first cycle after release, first frame_start at cycle 32.
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_an", an, 8'hFF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_fs", fs, 1'b0);
    end
    rst = 1'b0;
    fs_early = 0;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c == 1) begin
        chk("first_an", an, 8'hFE);
        chk("first_seg", seg, 7'h40);
        chk("first_nb_an", an_nb, 8'hFE);
        chk("first_nb_seg", seg_nb, 7'h40);
      end
      if (c < 32 && fs) fs_early++;
    end
    chk("fs_early", fs_early, 0);
    chk("fs_cycle32", fs, 1'b1);

    // Frame latched from reset stimulus: 12345678, all digits lit.
    display = 32'h0000_00A1;
    show_frame("f12345678", WALK,
               {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, -1, 32'h0, 1'b0);

    // 2. Leading-zero blanking of 000000A1.
    display = 32'hFFFF_FFFF;
    show_frame("fA1", 64'hFFFF_FFFF_FFFF_FDFE,
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h79}, -1, 32'h0, 1'b0);

    // 3. ALU -1 shown as raw hex.
    display = 32'h0000_0008;
    show_frame("fneg1", WALK,
               {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}, -1, 32'h0, 1'b0);

    // 4. No tearing: display changes to 9 at idx=3, digit 0 keeps showing 8.
    show_frame("f8", ONLY0,
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00}, 12, 32'h0000_0009, 1'b0);
    display = 32'h0000_0000;
    show_frame("f9", ONLY0,
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10}, -1, 32'h0, 1'b0);

    // 5. Zero value: blanking instance shows one '0', the other lights all 8.
    show_frame("f0", ONLY0,
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, -1, 32'h0, 1'b1);

    // 6. Reset mid-scan at idx=5, prescaler=2, then a full 4-cycle digit 0.
    display = 32'hCAFE_0123;
    for (int c = 0; c < 22; c++) step();
    rst = 1'b1;
    step();
    chk("midrst_an", an, 8'hFF);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_fs", fs, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("post_rst_an_c%0d", c), an, 8'hFE);
      chk($sformatf("post_rst_seg_c%0d", c), seg, 7'h40);
    end
    step();
    chk("post_rst_d1_an", an, 8'hFF);
    chk("post_rst_d1_seg", seg, 7'h7F);
    chk("post_rst_d1_nb_an", an_nb, 8'hFD);
    chk("post_rst_d1_nb_seg", seg_nb, 7'h40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
